// File: rtl/clk_monitor.sv
// clk_monitor: measures period and high time of an asynchronous clock (clk_in) in reference
// clock cycles, checks both against programmed windows and flags a lost input clock.
module clk_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXP_PERIOD = 100,
    parameter int unsigned PER_TOL    = 2,
    parameter int unsigned EXP_HIGH   = 50,
    parameter int unsigned HIGH_TOL   = 2,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             duty_ok,
    output logic             clk_lost,
    output logic [CNT_W-1:0] fail_cnt
);

    // Window bounds are held one bit wider than the counters so that neither the lower
    // bound (tolerance larger than expectation) nor the upper bound can wrap.
    localparam logic [CNT_W:0] PER_LO  = (PER_TOL > EXP_PERIOD) ? '0
                                         : (CNT_W+1)'(EXP_PERIOD - PER_TOL);
    localparam logic [CNT_W:0] PER_HI  = (CNT_W+1)'(EXP_PERIOD + PER_TOL);
    localparam logic [CNT_W:0] HIGH_LO = (HIGH_TOL > EXP_HIGH) ? '0
                                         : (CNT_W+1)'(EXP_HIGH - HIGH_TOL);
    localparam logic [CNT_W:0] HIGH_HI = (CNT_W+1)'(EXP_HIGH + HIGH_TOL);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } state_e;

    state_e           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             meas_valid_q, meas_valid_d;
    logic             freq_ok_q, freq_ok_d;
    logic             duty_ok_q, duty_ok_d;
    logic             clk_lost_q, clk_lost_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    logic             rise;
    logic             level;
    logic             per_in_win;
    logic             hi_in_win;
    logic             timed_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Two-flop synchronizer plus one history flop for edge detection.
    always_comb begin
        s1_d = clk_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign rise  = s2_q & ~s3_q;
    assign level = s2_q;

    // Window checks on the running counters, evaluated when a rise closes a period.
    always_comb begin
        per_in_win = ({1'b0, per_q} >= PER_LO)  && ({1'b0, per_q} <= PER_HI);
        hi_in_win  = ({1'b0, hi_q}  >= HIGH_LO) && ({1'b0, hi_q}  <= HIGH_HI);
        timed_out  = (per_q >= TIMEOUT_C);
    end

    // Next-state logic: FSM, measurement counters and registered outputs.
    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        hi_d         = hi_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        meas_valid_d = 1'b0;
        freq_ok_d    = freq_ok_q;
        duty_ok_d    = duty_ok_q;
        clk_lost_d   = clk_lost_q;

        if (!enable) begin
            // Disable wins from any state; an unfinished period is simply dropped.
            state_d    = StIdle;
            per_d      = '0;
            hi_d       = '0;
            freq_ok_d  = 1'b0;
            duty_ok_d  = 1'b0;
            clk_lost_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StArm;
                    per_d      = '0;
                    hi_d       = '0;
                    freq_ok_d  = 1'b0;
                    duty_ok_d  = 1'b0;
                    clk_lost_d = 1'b0;
                end
                StArm: begin
                    // The partial period before the first seen edge is never reported.
                    if (rise) begin
                        state_d    = StMeasure;
                        per_d      = CNT_ONE;
                        hi_d       = CNT_ONE;
                        clk_lost_d = 1'b0;
                    end
                end
                StMeasure: begin
                    // A rise on the timeout cycle still counts as a rise.
                    if (rise) begin
                        period_cnt_d = per_q;
                        high_cnt_d   = hi_q;
                        meas_valid_d = 1'b1;
                        freq_ok_d    = per_in_win;
                        duty_ok_d    = hi_in_win;
                        per_d        = CNT_ONE;
                        hi_d         = CNT_ONE;
                    end else if (timed_out) begin
                        state_d    = StArm;
                        clk_lost_d = 1'b1;
                        freq_ok_d  = 1'b0;
                        duty_ok_d  = 1'b0;
                        per_d      = '0;
                        hi_d       = '0;
                    end else begin
                        per_d = sat_inc(per_q);
                        if (level) begin
                            hi_d = sat_inc(hi_q);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Failure counter trails meas_valid by one cycle and saturates; only reset clears it.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (meas_valid_q && !(freq_ok_q && duty_ok_q)) begin
            fail_cnt_d = sat_inc(fail_cnt_q);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            per_q        <= '0;
            hi_q         <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            meas_valid_q <= 1'b0;
            freq_ok_q    <= 1'b0;
            duty_ok_q    <= 1'b0;
            clk_lost_q   <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            per_q        <= per_d;
            hi_q         <= hi_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            meas_valid_q <= meas_valid_d;
            freq_ok_q    <= freq_ok_d;
            duty_ok_q    <= duty_ok_d;
            clk_lost_q   <= clk_lost_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
    assign high_cnt   = high_cnt_q;
    assign meas_valid = meas_valid_q;
    assign freq_ok    = freq_ok_q;
    assign duty_ok    = duty_ok_q;
    assign clk_lost   = clk_lost_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: clk_in is built from (high, low) cycle pairs with edges mid-way
// between clk edges, so every measurement is exact. Expected reports go into a queue.
module tb_clk_monitor;

    localparam int CNT_W   = 16;
    localparam int EXP_P   = 100;
    localparam int P_TOL   = 2;
    localparam int EXP_H   = 50;
    localparam int H_TOL   = 2;
    localparam int TIMEOUT = 1000;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             clk_in;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             meas_valid;
    logic             freq_ok;
    logic             duty_ok;
    logic             clk_lost;
    logic [CNT_W-1:0] fail_cnt;

    clk_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_P),
        .PER_TOL    (P_TOL),
        .EXP_HIGH   (EXP_H),
        .HIGH_TOL   (H_TOL),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clk_in     (clk_in),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .freq_ok    (freq_ok),
        .duty_ok    (duty_ok),
        .clk_lost   (clk_lost),
        .fail_cnt   (fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit lost;
        bit chk_delta;
        int per;
        int hi;
        bit fok;
        bit dok;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state shared between driver and monitor.
    int mfail         = 0;
    bit fail_chk_pend = 0;
    bit lost_prev     = 0;
    bit measuring     = 0;
    int prev_h        = 0;
    int prev_l        = 0;
    int last_per      = 0;
    bit lost_chk_next = 0;
    int cyc           = 0;
    int last_mv_cyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int v, input int e, input int t);
        return (v >= e - t) && (v <= e + t);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " period_cnt"}, period_cnt, 0);
        chk({tag, " high_cnt"}, high_cnt, 0);
        chk({tag, " meas_valid"}, meas_valid, 0);
        chk({tag, " freq_ok"}, freq_ok, 0);
        chk({tag, " duty_ok"}, duty_ok, 0);
        chk({tag, " clk_lost"}, clk_lost, 0);
        chk({tag, " fail_cnt"}, fail_cnt, 0);
    endtask

    // One clk_in cycle: rise, h cycles high, l cycles low.
    // act: 0 plain, 1 drop enable during the low phase, 2 reset pulse during the low phase.
    task automatic run_period(input int h, input int l, input int act);
        exp_t e;
        bit   lost_now;
        bit   lost_pend;
        lost_pend = lost_chk_next;
        if (measuring) begin
            e.lost      = 1'b0;
            e.chk_delta = 1'b0;
            e.per       = prev_h + prev_l;
            e.hi        = prev_h;
            e.fok       = in_win(e.per, EXP_P, P_TOL);
            e.dok       = in_win(e.hi, EXP_H, H_TOL);
            sb.push_back(e);
            last_per = e.per;
        end
        lost_now = (h + l > TIMEOUT);
        if (lost_now) begin
            e.lost      = 1'b1;
            e.chk_delta = measuring;
            e.per       = 0;
            e.hi        = 0;
            e.fok       = 1'b0;
            e.dok       = 1'b0;
            sb.push_back(e);
        end
        measuring = !lost_now;
        prev_h    = h;
        prev_l    = l;
        for (int i = 0; i < h + l; i++) begin
            clk_in = (i < h);
            if (i == 4 && lost_pend) begin
                chk("clk_lost cleared by first rise", clk_lost, 0);
            end
            if (act == 1 && i == h + 4) begin
                enable    = 1'b0;
                measuring = 1'b0;
            end
            if (act == 1 && i == h + 7) begin
                chk("disabled meas_valid", meas_valid, 0);
                chk("disabled freq_ok", freq_ok, 0);
                chk("disabled duty_ok", duty_ok, 0);
                chk("disabled clk_lost", clk_lost, 0);
                chk("disabled period_cnt holds", period_cnt, last_per);
            end
            if (act == 1 && i == h + l - 6) begin
                enable = 1'b1;
            end
            if (act == 2 && i == h + 4) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero("async reset");
                sb.delete();
                mfail         = 0;
                fail_chk_pend = 0;
                lost_prev     = 0;
                measuring     = 0;
                last_per      = 0;
                #2 rst_n = 1'b1;
            end
            if (lost_now && (h + l >= TIMEOUT + 10) && i == h + l - 2) begin
                chk("clk_lost held", clk_lost, 1);
                chk("lost freq_ok", freq_ok, 0);
                chk("lost duty_ok", duty_ok, 0);
            end
            @(negedge clk);
        end
        lost_chk_next = lost_now;
    endtask

    // Monitor: pops an expectation whenever the DUT reports a measurement or a lost clock.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (fail_chk_pend) begin
                chk("fail_cnt after meas_valid", fail_cnt, mfail);
                fail_chk_pend = 0;
            end
            if (rst_n) begin
                if (meas_valid) begin
                    if (sb.size() == 0) begin
                        chk("meas_valid with empty scoreboard", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("report kind (meas)", e.lost, 0);
                        chk("period_cnt", period_cnt, e.per);
                        chk("high_cnt", high_cnt, e.hi);
                        chk("freq_ok", freq_ok, e.fok);
                        chk("duty_ok", duty_ok, e.dok);
                        chk("clk_lost at meas", clk_lost, 0);
                        if (!(e.fok && e.dok)) mfail++;
                        fail_chk_pend = 1;
                        last_mv_cyc   = cyc;
                    end
                end
                if (clk_lost && !lost_prev) begin
                    if (sb.size() == 0) begin
                        chk("clk_lost with empty scoreboard", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("report kind (lost)", e.lost, 1);
                        chk("freq_ok at lost", freq_ok, 0);
                        chk("duty_ok at lost", duty_ok, 0);
                        if (e.chk_delta) begin
                            chk("cycles from last report to clk_lost", cyc - last_mv_cyc, TIMEOUT);
                        end
                    end
                end
                lost_prev = clk_lost;
            end
        end
    end

    // Stimulus.
    initial begin
        int h;
        int l;
        int p;
        int act;
        rst_n  = 1'b0;
        enable = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal, then 30% duty.
        repeat (6) run_period(50, 50, 0);
        repeat (6) run_period(30, 70, 0);
        // Tolerance edges.
        run_period(49, 49, 0);
        run_period(51, 51, 0);
        run_period(51, 52, 0);
        run_period(48, 49, 0);
        run_period(50, 50, 0);
        // Lost clock and restart.
        run_period(50, 1500, 0);
        repeat (3) run_period(50, 50, 0);
        // Rise exactly on the timeout cycle, then one cycle past it.
        run_period(50, 950, 0);
        run_period(50, 951, 0);
        repeat (2) run_period(50, 50, 0);
        // Disable mid-period, then reset mid-period.
        run_period(50, 50, 1);
        repeat (3) run_period(50, 50, 0);
        run_period(50, 50, 2);
        repeat (3) run_period(50, 50, 0);

        // Randomized periods, mostly near the windows, some wide.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                p = EXP_P + int'($urandom_range(0, 8)) - 4;
                h = EXP_H + int'($urandom_range(0, 8)) - 4;
            end else begin
                h = int'($urandom_range(2, 150));
                p = h + int'($urandom_range(15, 150));
            end
            l   = p - h;
            act = 0;
            if (l >= 15) begin
                if ($urandom_range(0, 7) == 0) act = 1;
                else if ($urandom_range(0, 15) == 0) act = 2;
            end
            run_period(h, l, act);
        end
        run_period(50, 50, 0);
        repeat (10) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
